// File: rtl/pio_out_blink_if.sv
// ---------------------------------------------------------------------------
// pio_out_blink_if
//   Avalon-MM slave bus bundle for the pio_out_blink LED/GPO port.
//
//   Signals
//     address    [2:0]   word address
//     chipselect         slave select
//     write_n            active-low write strobe
//     writedata  [31:0]  write data
//     readdata   [31:0]  read data, combinational, zero wait states
//
//   Handshake: a write is taken on every rising clk edge where
//   chipselect=1 and write_n=0. There is no waitrequest; writes always
//   complete in that cycle. readdata follows address combinationally
//   with no read strobe, so the master may sample it in the same cycle.
//
//   Modports
//     master : drives address/chipselect/write_n/writedata, receives readdata
//     slave  : receives address/chipselect/write_n/writedata, drives readdata
// ---------------------------------------------------------------------------
interface pio_out_blink_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/pio_out_blink.sv
// ---------------------------------------------------------------------------
// pio_out_blink
//   Parametrised Avalon-MM output port for LED banks and general-purpose
//   outputs, with per-bit hardware blink driven by a programmable prescaler.
//
//   Parameters
//     WIDTH          number of output bits (1..32)
//     RESET_VALUE    DATA register value after reset
//     PRESC_W        width of the PERIOD register and prescaler counter (1..32)
//     DEFAULT_PERIOD PERIOD register value after reset (0 = blink frozen)
//
//   Ports
//     clk          system clock
//     reset        asynchronous, active-high reset
//     bus          Avalon-MM slave (pio_out_blink_if.slave)
//     out_port     driven outputs
//     blink_phase  current blink phase; also the prescaler's observable state
//
//   Register map (word address)
//     0 DATA        RW  WIDTH bits
//     1 BLINK_MASK  RW  WIDTH bits
//     2 PERIOD      RW  PRESC_W bits
//     3 STATUS      RO  bit0 = blink_phase
//     4 OUTSET      WO  DATA |= wdata   (PIO_OUT_BLINK_BITSET_EN only)
//     5 OUTCLEAR    WO  DATA &= ~wdata  (PIO_OUT_BLINK_BITSET_EN only)
//     6-7 reserved, read 0, writes ignored
//
//   Build option
//     PIO_OUT_BLINK_BITSET_EN  when defined, enables OUTSET/OUTCLEAR. When
//                              undefined, addresses 4 and 5 are reserved.
// ---------------------------------------------------------------------------
module pio_out_blink #(
   parameter int unsigned        WIDTH          = 8,
   parameter logic [WIDTH-1:0]   RESET_VALUE    = '0,
   parameter int unsigned        PRESC_W        = 24,
   parameter logic [PRESC_W-1:0] DEFAULT_PERIOD = '0
) (
   input  logic             clk,
   input  logic             reset,
   pio_out_blink_if.slave   bus,
   output logic [WIDTH-1:0] out_port,
   output logic             blink_phase
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_MASK     = 3'd1;
   localparam logic [2:0] ADDR_PERIOD   = 3'd2;
   localparam logic [2:0] ADDR_STATUS   = 3'd3;
`ifdef PIO_OUT_BLINK_BITSET_EN
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
`endif

   logic               wr;
   logic [WIDTH-1:0]   wdata_w;
   logic [PRESC_W-1:0] wdata_p;
   logic               unused_wdata;

   logic [WIDTH-1:0]   data_q;
   logic [WIDTH-1:0]   data_next;
   logic [WIDTH-1:0]   mask_q;
   logic [PRESC_W-1:0] period_q;
   logic [PRESC_W-1:0] count_q;
   logic               phase_q;
   logic               period_wr;

   assign wr        = bus.chipselect & ~bus.write_n;
   assign wdata_w   = bus.writedata[WIDTH-1:0];
   assign wdata_p   = bus.writedata[PRESC_W-1:0];
   // Upper writedata bits are intentionally ignored for narrow registers.
   assign unused_wdata = ^bus.writedata;
   assign period_wr = wr && (bus.address == ADDR_PERIOD);

   // -------------------------------------------------------------------------
   // DATA register next-state (plain write, plus optional set/clear).
   // -------------------------------------------------------------------------
   always_comb begin
      data_next = data_q;
      if (wr) begin
         case (bus.address)
            ADDR_DATA:     data_next = wdata_w;
`ifdef PIO_OUT_BLINK_BITSET_EN
            ADDR_OUTSET:   data_next = data_q | wdata_w;
            ADDR_OUTCLEAR: data_next = data_q & ~wdata_w;
`endif
            default:       data_next = data_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= RESET_VALUE;
      end else begin
         data_q <= data_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q <= '0;
      end else if (wr && (bus.address == ADDR_MASK)) begin
         mask_q <= wdata_w;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_q <= DEFAULT_PERIOD;
      end else if (period_wr) begin
         period_q <= wdata_p;
      end
   end

   // -------------------------------------------------------------------------
   // Prescaler. A PERIOD write restarts the half-cycle with phase=1 and wins
   // over a toggle falling due on the same edge. Because count restarts at 0
   // whenever PERIOD changes and wraps on equality, it never exceeds PERIOD.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         phase_q <= 1'b1;
      end else if (period_wr) begin
         count_q <= '0;
         phase_q <= 1'b1;
      end else if (period_q == '0) begin
         count_q <= '0;
         phase_q <= 1'b1;
      end else if (count_q == period_q) begin
         count_q <= '0;
         phase_q <= ~phase_q;
      end else begin
         count_q <= count_q + PRESC_W'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Zero-wait-state read mux; WO and reserved addresses read 0.
   // -------------------------------------------------------------------------
   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_DATA:   bus.readdata[WIDTH-1:0]   = data_q;
         ADDR_MASK:   bus.readdata[WIDTH-1:0]   = mask_q;
         ADDR_PERIOD: bus.readdata[PRESC_W-1:0] = period_q;
         ADDR_STATUS: bus.readdata[0]           = phase_q;
         default:     bus.readdata              = '0;
      endcase
   end

   // Masked bits are forced low during the off phase.
   assign out_port    = data_q & ~(mask_q & {WIDTH{~phase_q}});
   assign blink_phase = phase_q;

endmodule
